// File: rtl/proc_b_drain.sv
// Drain for the last processor_B column: packs GF elements into OUT_WIDTH words
// and buffers the words in a small FIFO with a registered-only in_ready.
module proc_b_drain #(
    parameter int GF_BIT     = 4,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic [GF_BIT-1:0]                      in_data,
    input  logic                                   in_last,
    output logic                                   in_ready,
    output logic                                   out_valid,
    output logic [OUT_WIDTH-1:0]                   out_data,
    output logic [$clog2(OUT_WIDTH/GF_BIT):0]      out_nelem,
    output logic                                   out_last,
    input  logic                                   out_ready
);

    localparam int ELEMS   = OUT_WIDTH / GF_BIT;
    localparam int NELEM_W = $clog2(ELEMS) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [NELEM_W-1:0] LAST_SLOT = NELEM_W'(ELEMS - 1);
    localparam logic [PTR_W:0]     DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    function automatic logic [OUT_WIDTH-1:0] insert_elem(
        input logic [OUT_WIDTH-1:0] word,
        input logic [NELEM_W-1:0]   slot,
        input logic [GF_BIT-1:0]    elem
    );
        logic [OUT_WIDTH-1:0] res;
        res = word;
        for (int k = 0; k < ELEMS; k++) begin
            if (slot == NELEM_W'(k)) res[k*GF_BIT +: GF_BIT] = elem;
        end
        return res;
    endfunction

    logic [NELEM_W-1:0]   elem_cnt_p0;
    logic [OUT_WIDTH-1:0] pack_p0;
    logic [OUT_WIDTH-1:0] word_ins;
    logic [NELEM_W-1:0]   push_nelem;
    logic                 accept;
    logic                 push;
    logic                 pop;

    logic [OUT_WIDTH-1:0] mem_data  [FIFO_DEPTH];
    logic [NELEM_W-1:0]   mem_nelem [FIFO_DEPTH];
    logic                 mem_last  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_p1;
    logic [PTR_W-1:0]     rd_ptr_p1;
    logic [PTR_W:0]       count_p1;

    assign in_ready   = (count_p1 < DEPTH_C);
    assign out_valid  = (count_p1 != '0);
    assign accept     = in_valid && in_ready;
    // A last element that also fills the word closes it once, never twice.
    assign push       = accept && (in_last || (elem_cnt_p0 == LAST_SLOT));
    assign pop        = out_valid && out_ready;
    assign word_ins   = insert_elem(pack_p0, elem_cnt_p0, in_data);
    assign push_nelem = elem_cnt_p0 + 1'b1;

    // Stage p0: element packing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            elem_cnt_p0 <= '0;
            pack_p0     <= '0;
        end else if (accept) begin
            if (push) begin
                elem_cnt_p0 <= '0;
                pack_p0     <= '0;
            end else begin
                elem_cnt_p0 <= push_nelem;
                pack_p0     <= word_ins;
            end
        end
    end

    // Stage p1: word FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_p1]  <= word_ins;
            mem_nelem[wr_ptr_p1] <= push_nelem;
            mem_last[wr_ptr_p1]  <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (push) wr_ptr_p1 <= wr_ptr_p1 + 1'b1;
            if (pop)  rd_ptr_p1 <= rd_ptr_p1 + 1'b1;
            case ({push, pop})
                2'b10:   count_p1 <= count_p1 + 1'b1;
                2'b01:   count_p1 <= count_p1 - 1'b1;
                default: count_p1 <= count_p1;
            endcase
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign out_data  = out_valid ? mem_data[rd_ptr_p1]  : '0;
    assign out_nelem = out_valid ? mem_nelem[rd_ptr_p1] : '0;
    assign out_last  = out_valid ? mem_last[rd_ptr_p1]  : 1'b0;

endmodule
